pa_clic_arb_scan: RTL and testbench



---
 rtl/pa_clic_arb_scan.sv | 159 +++++++++++++++
 tb/tb_pa_clic_arb_scan.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_clic_arb_scan.sv
// Sequential CLIC scan arbiter: one kid group per cycle, publishes the sweep winner, acks it on core accept.
// Optional feature macro: CLIC_ARB_THRESH_EN (winner priority must exceed cpu_clic_thresh).
module pa_clic_arb_scan #(
  parameter int INT_NUM        = 64,
  parameter int GRP            = 8,
  parameter int ID_W           = 6,
  parameter int CLICINTCTLBITS = 3
) (
  input  logic                                   clic_clk,
  input  logic                                   cpurst,
  input  logic [INT_NUM-1:0]                     kid_arb_int_req,
  input  logic [INT_NUM*(CLICINTCTLBITS+1)-1:0]  kid_arb_int_all,
  input  logic [INT_NUM-1:0]                     kid_arb_int_hv,
  input  logic [CLICINTCTLBITS-1:0]              cpu_clic_thresh,
  input  logic                                   ctrl_arb_int_ack,
  output logic                                   arb_ctrl_int_vld,
  output logic [ID_W-1:0]                        arb_ctrl_int_id,
  output logic [CLICINTCTLBITS:0]                arb_ctrl_int_all,
  output logic                                   arb_ctrl_int_hv,
  output logic [INT_NUM-1:0]                     arb_kid_ack_int
);

  localparam int NGRP = INT_NUM / GRP;
  localparam int AW   = CLICINTCTLBITS + 1;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {SCAN, ACK, SETTLE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     grp_cnt_q;
  logic              best_found_q;
  logic [ID_W-1:0]   best_id_q;
  logic [AW-1:0]     best_all_q;
  logic              best_hv_q;
  logic              out_vld_q;
  logic [ID_W-1:0]   out_id_q;
  logic [AW-1:0]     out_all_q;
  logic              out_hv_q;
  logic [INT_NUM-1:0] ack_q;

  int                grp_base;
  logic              grp_found;
  logic [ID_W-1:0]   grp_id;
  logic [AW-1:0]     grp_all;
  logic              grp_hv;
  logic              mrg_found;
  logic [ID_W-1:0]   mrg_id;
  logic [AW-1:0]     mrg_all;
  logic              mrg_hv;
  logic              thresh_pass;
  logic              take_ack;
  logic              sweep_end;

  assign grp_base = int'(grp_cnt_q) * GRP;

  // Ascending scan with strict compare keeps the lowest ID on ties.
  always_comb begin
    grp_found = 1'b0;
    grp_id    = '0;
    grp_all   = '0;
    grp_hv    = 1'b0;
    for (int j = 0; j < GRP; j++) begin
      if (kid_arb_int_req[grp_base + j] &&
          (!grp_found || kid_arb_int_all[(grp_base + j)*AW +: AW] > grp_all)) begin
        grp_found = 1'b1;
        grp_id    = ID_W'(grp_base + j);
        grp_all   = kid_arb_int_all[(grp_base + j)*AW +: AW];
        grp_hv    = kid_arb_int_hv[grp_base + j];
      end
    end
  end

  always_comb begin
    mrg_found = (grp_cnt_q == '0) ? 1'b0 : best_found_q;
    mrg_id    = (grp_cnt_q == '0) ? '0   : best_id_q;
    mrg_all   = (grp_cnt_q == '0) ? '0   : best_all_q;
    mrg_hv    = (grp_cnt_q == '0) ? 1'b0 : best_hv_q;
    if (grp_found && (!mrg_found || grp_all > mrg_all)) begin
      mrg_found = 1'b1;
      mrg_id    = grp_id;
      mrg_all   = grp_all;
      mrg_hv    = grp_hv;
    end
  end

`ifdef CLIC_ARB_THRESH_EN
  assign thresh_pass = mrg_all[CLICINTCTLBITS-1:0] > cpu_clic_thresh;
`else
  logic unused_thresh;
  assign unused_thresh = ^cpu_clic_thresh;
  assign thresh_pass   = 1'b1;
`endif

  assign arb_ctrl_int_vld = out_vld_q & kid_arb_int_req[out_id_q];
  assign arb_ctrl_int_id  = out_id_q;
  assign arb_ctrl_int_all = out_all_q;
  assign arb_ctrl_int_hv  = out_hv_q;
  assign arb_kid_ack_int  = ack_q;

  assign take_ack  = (state_q == SCAN) && ctrl_arb_int_ack && arb_ctrl_int_vld;
  assign sweep_end = (state_q == SCAN) && (grp_cnt_q == CW'(NGRP - 1));

  always_ff @(posedge clic_clk) begin
    if (cpurst) state_q <= SCAN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (take_ack) state_d = ACK;
      ACK:     state_d = SETTLE;
      SETTLE:  state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  // An accepted ack abandons the sweep in progress, including on its final cycle.
  always_ff @(posedge clic_clk) begin
    if (cpurst) begin
      grp_cnt_q    <= '0;
      best_found_q <= 1'b0;
      best_id_q    <= '0;
      best_all_q   <= '0;
      best_hv_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_id_q     <= '0;
      out_all_q    <= '0;
      out_hv_q     <= 1'b0;
      ack_q        <= '0;
    end else begin
      ack_q <= '0;
      if (state_q == SCAN) begin
        if (take_ack) begin
          out_vld_q <= 1'b0;
          ack_q     <= {{(INT_NUM-1){1'b0}}, 1'b1} << out_id_q;
          grp_cnt_q <= '0;
        end else begin
          best_found_q <= mrg_found;
          best_id_q    <= mrg_id;
          best_all_q   <= mrg_all;
          best_hv_q    <= mrg_hv;
          if (sweep_end) begin
            out_vld_q <= mrg_found & thresh_pass;
            out_id_q  <= mrg_id;
            out_all_q <= mrg_all;
            out_hv_q  <= mrg_hv;
            grp_cnt_q <= '0;
          end else begin
            grp_cnt_q <= grp_cnt_q + CW'(1);
          end
        end
      end else begin
        grp_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pa_clic_arb_scan.sv
// Self-checking bench for pa_clic_arb_scan: directed scenarios plus random sweeps against a kid-array model.
module tb_pa_clic_arb_scan;

  logic         clk = 1'b0;
  logic         cpurst;
  logic [63:0]  req;
  logic [255:0] all_v;
  logic [63:0]  hv;
  logic [2:0]   thresh;
  logic         ack;
  logic         vld;
  logic [5:0]   id;
  logic [3:0]   o_all;
  logic         o_hv;
  logic [63:0]  ack_int;

  logic [3:0]   kid_all [64];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  pa_clic_arb_scan dut (
    .clic_clk         (clk),
    .cpurst           (cpurst),
    .kid_arb_int_req  (req),
    .kid_arb_int_all  (all_v),
    .kid_arb_int_hv   (hv),
    .cpu_clic_thresh  (thresh),
    .ctrl_arb_int_ack (ack),
    .arb_ctrl_int_vld (vld),
    .arb_ctrl_int_id  (id),
    .arb_ctrl_int_all (o_all),
    .arb_ctrl_int_hv  (o_hv),
    .arb_kid_ack_int  (ack_int)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < 64; i++) all_v[i*4 +: 4] = kid_all[i];
  endtask

  task automatic clear_kids();
    req = '0;
    hv  = '0;
    for (int i = 0; i < 64; i++) kid_all[i] = 4'd0;
    drive();
  endtask

  // Winner = highest {mode,prio} among requesting kids, lowest ID on ties.
  task automatic model(output bit f, output int wid, output logic [3:0] wall, output logic whv);
    f = 0; wid = 0; wall = 4'd0; whv = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (req[i] && (!f || kid_all[i] > wall)) begin
        f = 1; wid = i; wall = kid_all[i]; whv = hv[i];
      end
    end
  endtask

  function automatic bit thresh_ok(input logic [3:0] a);
`ifdef CLIC_ARB_THRESH_EN
    return a[2:0] > thresh;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_pub(input string tag);
    bit f; int wid; logic [3:0] wall; logic whv;
    model(f, wid, wall, whv);
    check({tag, "_vld"}, vld, f && thresh_ok(wall) && req[wid]);
    if (f) begin
      check({tag, "_id"}, id, wid);
      check({tag, "_all"}, o_all, wall);
      check({tag, "_hv"}, o_hv, whv);
    end
  endtask

  task automatic run_sweep(input string tag);
    for (int s = 0; s < 8; s++) begin
      step();
      check({tag, "_noack"}, ack_int, 64'd0);
    end
  endtask

  initial begin
    bit f; int wid; logic [3:0] wall; logic whv;
    logic [63:0] one;

    cpurst = 1'b1; ack = 1'b0; thresh = 3'd0;
    all_v = '0;
    clear_kids();
    step(); step();
    check("rst_vld", vld, 1'b0);
    check("rst_id", id, 6'd0);
    check("rst_all", o_all, 4'd0);
    check("rst_hv", o_hv, 1'b0);
    check("rst_ack", ack_int, 64'd0);
    cpurst = 1'b0;

    // Three empty sweeps
    for (int s = 0; s < 24; s++) begin
      step();
      check("idle_vld", vld, 1'b0);
      check("idle_ack", ack_int, 64'd0);
    end

    // Kids 5 and 40
    req[5] = 1'b1; kid_all[5] = 4'b1011;
    req[40] = 1'b1; kid_all[40] = 4'b1110;
    drive();
    for (int s = 0; s < 7; s++) begin
      step();
      check("k40_early_vld", vld, 1'b0);
    end
    step();
    check("k40_vld", vld, 1'b1);
    check("k40_id", id, 6'd40);
    check("k40_all", o_all, 4'b1110);
    check_pub("k40");

    // Tie between kids 3 and 17, then ack
    clear_kids();
    req[3] = 1'b1; kid_all[3] = 4'b1101;
    req[17] = 1'b1; kid_all[17] = 4'b1101;
    drive();
    run_sweep("tie");
    check("tie_id", id, 6'd3);
    check_pub("tie");
    ack = 1'b1;
    step();
    check("tie_ackpulse", ack_int, 64'd8);
    check("tie_vld_after_ack", vld, 1'b0);
    ack = 1'b0; req[3] = 1'b0;
    step();
    check("tie_ack_one_cycle", ack_int, 64'd0);
    step();
    check("tie_settle_vld", vld, 1'b0);
    for (int s = 0; s < 7; s++) begin
      step();
      check("tie_resweep_vld", vld, 1'b0);
      check("tie_resweep_ack", ack_int, 64'd0);
    end
    step();
    check("tie_next_id", id, 6'd17);
    check_pub("tie_next");

    // Kid 9 published, then request drops
    clear_kids();
    req[9] = 1'b1; kid_all[9] = 4'b1010; hv[9] = 1'b1;
    drive();
    run_sweep("k9");
    check("k9_vld", vld, 1'b1);
    check("k9_id", id, 6'd9);
    check("k9_hv", o_hv, 1'b1);
    req[9] = 1'b0;
    #1;
    check("k9_drop_vld", vld, 1'b0);
    check("k9_drop_id_hold", id, 6'd9);
    run_sweep("k9_empty");
    check("k9_empty_vld", vld, 1'b0);
    req[9] = 1'b1;
    #1;
    check("k9_restore_masked", vld, 1'b0);
    run_sweep("k9_again");
    check("k9_again_vld", vld, 1'b1);
    check("k9_again_id", id, 6'd9);

    // Ack on the sweep-end cycle while kid 50 outranks kid 9
    req[50] = 1'b1; kid_all[50] = 4'b1111;
    drive();
    for (int s = 0; s < 7; s++) step();
    ack = 1'b1;
    step();
    one = 64'd1 << 9;
    check("se_ackpulse", ack_int, one);
    check("se_vld", vld, 1'b0);
    ack = 1'b0; req[9] = 1'b0;
    step();
    check("se_ack_one_cycle", ack_int, 64'd0);
    step();
    for (int s = 0; s < 7; s++) begin
      step();
      check("se_wait_vld", vld, 1'b0);
    end
    step();
    check("se_vld_new", vld, 1'b1);
    check("se_id_new", id, 6'd50);
    check("se_all_new", o_all, 4'b1111);

    // Threshold
    clear_kids();
    thresh = 3'd5;
    req[20] = 1'b1; kid_all[20] = 4'b1101;
    drive();
    run_sweep("th5");
`ifdef CLIC_ARB_THRESH_EN
    check("th_eq_vld", vld, 1'b0);
`else
    check("th_eq_vld", vld, 1'b1);
`endif
    check_pub("th_eq");
    kid_all[20] = 4'b1110;
    drive();
    run_sweep("th6");
    check("th_gt_vld", vld, 1'b1);
    check_pub("th_gt");
    thresh = 3'd0;

    // Ack while nothing valid is ignored
    clear_kids();
    run_sweep("ign_empty");
    req[2] = 1'b1; kid_all[2] = 4'b0001;
    drive();
    ack = 1'b1;
    run_sweep("ign");
    ack = 1'b0;
    check("ign_vld", vld, 1'b1);
    check("ign_id", id, 6'd2);

    // Reset during the ack pulse
    ack = 1'b1;
    step();
    check("rack_pulse", ack_int, 64'd4);
    ack = 1'b0; cpurst = 1'b1;
    step();
    check("rack_ack", ack_int, 64'd0);
    check("rack_vld", vld, 1'b0);
    check("rack_id", id, 6'd0);
    check("rack_all", o_all, 4'd0);
    step();
    check("rack_ack2", ack_int, 64'd0);
    cpurst = 1'b0;
    clear_kids();

    // Random sweeps with occasional acks
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 64; i++) begin
        req[i]     = ($urandom_range(0, 3) == 0);
        kid_all[i] = 4'($urandom_range(0, 15));
        hv[i]      = 1'($urandom_range(0, 1));
      end
      thresh = 3'($urandom_range(0, 7));
      drive();
      run_sweep("rnd");
      check_pub("rnd");
      model(f, wid, wall, whv);
      if (f && thresh_ok(wall) && $urandom_range(0, 1) == 1) begin
        ack = 1'b1;
        step();
        one = 64'd1 << wid;
        check("rnd_ackpulse", ack_int, one);
        ack = 1'b0; req[wid] = 1'b0;
        step();
        check("rnd_ack_one_cycle", ack_int, 64'd0);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
